// File: rtl/tile_csr_host_if.sv
// Command/response port of the tile CSR host.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that transfer, and never waits on ready before raising valid.
interface tile_csr_host_if #(
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [CSR_IN_WIDTH-1:0]  cmd_csr;
  logic [REG_WIDTH-1:0]     cmd_a;
  logic [REG_WIDTH-1:0]     cmd_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [CSR_OUT_WIDTH-1:0] rsp_csr;
  logic [REG_WIDTH-1:0]     rsp_data;
  logic                     rsp_timeout;

  // Command producer / response consumer side.
  modport master (
    output cmd_valid, cmd_csr, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_csr, rsp_data, rsp_timeout
  );

  // Side implemented by tile_csr_host.
  modport slave (
    input  cmd_valid, cmd_csr, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_csr, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/tile_csr_host.sv
// Harness-side initiator for a user tile's CSR/data-register interface.
// One command at a time: present csr/operands to the tile, wait for the tile
// to consume the csr word and publish its result, then hand back a response.
// A cycle timer aborts commands the tile never accepts or never answers.
module tile_csr_host #(
  parameter int REG_WIDTH      = 32,
  parameter int CSR_IN_WIDTH   = 16,
  parameter int CSR_OUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     arst_n,
  tile_csr_host_if.slave           host,
  output logic                     tile_en,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  input  logic                     csr_in_re,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_out_we,
  input  logic [REG_WIDTH-1:0]     data_reg_c,
  output logic [1:0]               dbg_state
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     tile_en_q, tile_en_d;
  logic [CSR_IN_WIDTH-1:0]  csr_in_q, csr_in_d;
  logic [REG_WIDTH-1:0]     reg_a_q, reg_a_d;
  logic [REG_WIDTH-1:0]     reg_b_q, reg_b_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [CSR_OUT_WIDTH-1:0] rsp_csr_q, rsp_csr_d;
  logic [REG_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                     rsp_timeout_q, rsp_timeout_d;

  // All outputs come straight from flops so the tile sees glitch-free levels.
  assign host.cmd_ready   = cmd_ready_q;
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_csr     = rsp_csr_q;
  assign host.rsp_data    = rsp_data_q;
  assign host.rsp_timeout = rsp_timeout_q;
  assign tile_en          = tile_en_q;
  assign csr_in           = csr_in_q;
  assign data_reg_a       = reg_a_q;
  assign data_reg_b       = reg_b_q;
  assign dbg_state        = state_q;

  // State and output registers; reset parks the block idle and ready.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      cmd_ready_q   <= 1'b1;
      tile_en_q     <= 1'b0;
      csr_in_q      <= '0;
      reg_a_q       <= '0;
      reg_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_csr_q     <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cmd_ready_q   <= cmd_ready_d;
      tile_en_q     <= tile_en_d;
      csr_in_q      <= csr_in_d;
      reg_a_q       <= reg_a_d;
      reg_b_q       <= reg_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_csr_q     <= rsp_csr_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state and next-output logic. A completing tile event always takes
  // priority over the timeout in the same cycle; csr_in_re alone on the last
  // timer cycle does not complete the command.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cmd_ready_d   = cmd_ready_q;
    tile_en_d     = tile_en_q;
    csr_in_d      = csr_in_q;
    reg_a_d       = reg_a_q;
    reg_b_d       = reg_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_csr_d     = rsp_csr_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid) begin
          state_d     = S_ISSUE;
          timer_d     = '0;
          cmd_ready_d = 1'b0;
          tile_en_d   = 1'b1;
          // Bit 0 is the START strobe; the block always sets it.
          csr_in_d    = host.cmd_csr | CSR_IN_WIDTH'(1);
          reg_a_d     = host.cmd_a;
          reg_b_d     = host.cmd_b;
        end
      end

      S_ISSUE, S_WAIT_RSP: begin
        timer_d = timer_q + 1'b1;
        if (csr_out_we && (csr_in_re || state_q == S_WAIT_RSP)) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_csr_d     = csr_out;
          rsp_data_d    = data_reg_c;
          rsp_timeout_d = 1'b0;
          tile_en_d     = 1'b0;
          csr_in_d      = '0;
          reg_a_d       = '0;
          reg_b_d       = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_csr_d     = '0;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          tile_en_d     = 1'b0;
          csr_in_d      = '0;
          reg_a_d       = '0;
          reg_b_d       = '0;
        end else if (state_q == S_ISSUE && csr_in_re) begin
          state_d  = S_WAIT_RSP;
          csr_in_d = '0;
        end
      end

      S_RESP: begin
        if (host.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tile_csr_host.sv
// Bench for tile_csr_host: directed scenarios plus randomized commands with a
// randomized tile, checked against a cycle-index model of the command rules.
module tb_tile_csr_host;
  localparam int RW  = 32;
  localparam int CIW = 16;
  localparam int COW = 16;
  localparam int T   = 16;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic           tile_en;
  logic [CIW-1:0] csr_in;
  logic           csr_in_re = 1'b0;
  logic [RW-1:0]  data_reg_a;
  logic [RW-1:0]  data_reg_b;
  logic [COW-1:0] csr_out = '0;
  logic           csr_out_we = 1'b0;
  logic [RW-1:0]  data_reg_c = '0;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW+COW:0] exp_q[$];

  tile_csr_host_if #(.REG_WIDTH(RW), .CSR_IN_WIDTH(CIW), .CSR_OUT_WIDTH(COW)) bus ();

  tile_csr_host #(
    .REG_WIDTH(RW), .CSR_IN_WIDTH(CIW), .CSR_OUT_WIDTH(COW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .host       (bus.slave),
    .tile_en    (tile_en),
    .csr_in     (csr_in),
    .csr_in_re  (csr_in_re),
    .data_reg_a (data_reg_a),
    .data_reg_b (data_reg_b),
    .csr_out    (csr_out),
    .csr_out_we (csr_out_we),
    .data_reg_c (data_reg_c),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check_eq({tag, "_tile_en"}, tile_en, 0);
    check_eq({tag, "_csr_in"}, csr_in, 0);
    check_eq({tag, "_data_reg_a"}, data_reg_a, 0);
    check_eq({tag, "_data_reg_b"}, data_reg_b, 0);
  endtask

  // One full command. Cycle index 0 is the first cycle csr_in is visible.
  // The tile pulses csr_in_re at index r and csr_out_we at index w (w >= r);
  // indices at or past T never happen because the command is over by then.
  // Model: the command completes at index w if w < T, otherwise it times
  // out after index T-1. csr_in shows the START-forced word through index r.
  task automatic run_cmd(input logic [CIW-1:0] ccsr, input logic [RW-1:0] a,
                         input logic [RW-1:0] b, input int r, input int w,
                         input logic [COW-1:0] cout, input logic [RW-1:0] cdata,
                         input int hold);
    logic [CIW-1:0]  exp_csr_in;
    logic [RW+COW:0] got;
    int              last;
    exp_csr_in = ccsr;
    exp_csr_in[0] = 1'b1;
    if (w < T) exp_q.push_back({1'b0, cout, cdata});
    else       exp_q.push_back({1'b1, {COW{1'b0}}, {RW{1'b0}}});
    last = (w < T) ? w : T - 1;

    bus.cmd_valid = 1'b1;
    bus.cmd_csr   = ccsr;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(negedge clk);
    check_eq("accept_cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_csr   = CIW'($urandom);
    bus.cmd_a     = $urandom;
    bus.cmd_b     = $urandom;

    for (int idx = 0; idx <= last; idx++) begin
      csr_in_re  = (idx == r);
      csr_out_we = (idx == w);
      csr_out    = (idx == w) ? cout : COW'($urandom);
      data_reg_c = (idx == w) ? cdata : RW'($urandom);
      @(negedge clk);
      check_eq("busy_csr_in", csr_in, (idx <= r) ? exp_csr_in : '0);
      check_eq("busy_tile_en", tile_en, 1);
      check_eq("busy_data_reg_a", data_reg_a, a);
      check_eq("busy_data_reg_b", data_reg_b, b);
      check_eq("busy_rsp_valid", bus.rsp_valid, 0);
      check_eq("busy_cmd_ready", bus.cmd_ready, 0);
      tick();
    end
    csr_in_re  = 1'b0;
    csr_out_we = 1'b0;

    // Response phase: stray tile pulses and a pending command must not disturb it.
    for (int h = 0; h <= hold; h++) begin
      bus.rsp_ready = (h == hold);
      bus.cmd_valid = 1'($urandom_range(0, 1));
      csr_in_re     = 1'($urandom_range(0, 1));
      csr_out_we    = 1'($urandom_range(0, 1));
      csr_out       = COW'($urandom);
      data_reg_c    = $urandom;
      @(negedge clk);
      got = {bus.rsp_timeout, bus.rsp_csr, bus.rsp_data};
      check_eq("rsp_valid", bus.rsp_valid, 1);
      check_eq("rsp_payload", got, exp_q[0]);
      check_eq("rsp_cmd_ready", bus.cmd_ready, 0);
      check_eq("rsp_tile_en", tile_en, 0);
      check_eq("rsp_csr_in", csr_in, 0);
      check_eq("rsp_data_reg_a", data_reg_a, 0);
      tick();
    end
    void'(exp_q.pop_front());
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;

    // Idle cycle with stray tile pulses: block must stay idle.
    csr_in_re  = 1'b1;
    csr_out_we = 1'b1;
    @(negedge clk);
    check_eq("post_rsp_valid", bus.rsp_valid, 0);
    check_eq("post_cmd_ready", bus.cmd_ready, 1);
    tick();
    csr_in_re  = 1'b0;
    csr_out_we = 1'b0;
    @(negedge clk);
    check_eq("idle_tile_en", tile_en, 0);
    check_eq("idle_cmd_ready", bus.cmd_ready, 1);
    tick();
  endtask

  // Reset asserted while the block waits for the tile's answer.
  task automatic reset_in_wait();
    bus.cmd_valid = 1'b1;
    bus.cmd_csr   = 16'h1234;
    bus.cmd_a     = 32'hA5A5_0001;
    bus.cmd_b     = 32'h5A5A_0002;
    tick();
    bus.cmd_valid = 1'b0;
    csr_in_re = 1'b1;
    tick();
    csr_in_re = 1'b0;
    tick();
    @(negedge clk);
    check_eq("wait_tile_en", tile_en, 1);
    check_eq("wait_csr_in", csr_in, 0);
    #2 arst_n = 1'b0;
    #1;
    check_quiet_outputs("async_rst");
    check_eq("async_rst_rsp_timeout", bus.rsp_timeout, 0);
    @(posedge clk);
    #3 arst_n = 1'b1;
    tick();
    csr_out_we = 1'b1;
    csr_out    = 16'hBEEF;
    data_reg_c = 32'hDEAD_BEEF;
    tick();
    csr_out_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet_outputs("after_rst");
      check_eq("after_rst_rsp_csr", bus.rsp_csr, 0);
      tick();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_csr   = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet_outputs("reset");
    check_eq("reset_rsp_csr", bus.rsp_csr, 0);
    check_eq("reset_rsp_data", bus.rsp_data, 0);
    check_eq("reset_rsp_timeout", bus.rsp_timeout, 0);
    arst_n = 1'b1;
    tick();

    // Directed scenarios.
    run_cmd(16'h0040, 32'd5, 32'd7, 1, 4, 16'h8001, 32'd12, 0);
    run_cmd(16'h0041, 32'h1111_2222, 32'h3333_4444, 0, 0, 16'h0003, 32'hFFFF_FFFF, 0);
    run_cmd(16'hFFFE, 32'd1, 32'd2, 100, 100, 16'h7777, 32'h7777, 1);
    run_cmd(16'h0100, 32'd9, 32'd10, 3, T - 1, 16'h4242, 32'hCAFE_F00D, 0);
    run_cmd(16'h0100, 32'd9, 32'd10, 3, T, 16'h4242, 32'hCAFE_F00D, 0);
    run_cmd(16'h0200, 32'hABCD, 32'h1234, T - 1, T - 1, 16'h0101, 32'h0202, 0);
    run_cmd(16'h0300, 32'd3, 32'd4, 2, 6, 16'h0F0F, 32'h1357_9BDF, 10);

    reset_in_wait();
    run_cmd(16'h0042, 32'd8, 32'd9, 0, 2, 16'h00AA, 32'h55, 0);

    // Randomized commands and tile timing.
    for (int n = 0; n < 40; n++) begin
      int r;
      int w;
      r = $urandom_range(0, T + 2);
      w = r + $urandom_range(0, 5);
      run_cmd(CIW'($urandom), $urandom, $urandom, r, w, COW'($urandom), $urandom,
              $urandom_range(0, 3));
    end

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
